// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, default widths,
// FSM state type and the golden result model used by ALU_CMD_CHECK_EN.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } drv_state_e;

    function automatic logic [ALU_DATA_W-1:0] alu_expected(
        input logic [ALU_DATA_W-1:0] a,
        input logic [ALU_DATA_W-1:0] b,
        input logic [ALU_OP_W-1:0]   op
    );
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count; full/empty
// are decoded from the count so they never see a same-cycle pop.
module alu_cmd_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues tagged ALU commands, drives them onto the ALU pins and returns
// tagged responses. Optional golden-model check: define ALU_CMD_CHECK_EN.
//
// state    | meaning
// IDLE     | engine empty, waiting for a queued command
// DRIVE    | operands on ALU pins, settle counter running down
// RESP     | response held until consumer handshake
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int TAG_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_illegal,
    output logic              rsp_mismatch,
    output logic              busy
);

    localparam int FW    = 2*DATA_W + OP_W + TAG_W;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    drv_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                valid_q, valid_d, ill_q, ill_d, mm_q, mm_d;

    logic                fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]       fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [DATA_W-1:0]   h_a, h_b;
    logic [OP_W-1:0]     h_op;
    logic [TAG_W-1:0]    h_tag;
    logic                load;

    alu_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_a, cmd_b, cmd_op, cmd_tag}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign {h_a, h_b, h_op, h_tag} = fifo_head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            tag_q    <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
            ill_q    <= 1'b0;
            mm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            tag_q    <= tag_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
            ill_q    <= ill_d;
            mm_q     <= mm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        tag_d    = tag_q;
        res_d    = res_q;
        valid_d  = valid_q;
        ill_d    = ill_q;
        mm_d     = mm_q;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    res_d   = alu_result;
                    valid_d = 1'b1;
                    ill_d   = (alu_op_q > OP_W'(OP_XOR));
`ifdef ALU_CMD_CHECK_EN
                    mm_d    = (alu_result != alu_expected(alu_a_q, alu_b_q, alu_op_q));
`else
                    mm_d    = 1'b0;
`endif
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    if (!fifo_empty) load = 1'b1;
                    else             state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Shared issue path so RESP can chain straight into DRIVE.
        if (load) begin
            alu_a_d  = h_a;
            alu_b_d  = h_b;
            alu_op_d = h_op;
            tag_d    = h_tag;
            cnt_d    = CNT_LOAD;
            state_d  = ST_DRIVE;
        end
        fifo_pop = load;
    end

    assign cmd_ready    = !fifo_full;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_valid    = valid_q;
    assign rsp_result   = res_q;
    assign rsp_tag      = tag_q;
    assign rsp_illegal  = ill_q;
    assign rsp_mismatch = mm_q;
    assign busy         = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU that can be
// made to corrupt its LSB on demand.
module tb_alu_cmd_driver;

    localparam int SETTLE = 1;
`ifdef ALU_CMD_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_tag = '0;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic [1:0] rsp_tag;
    logic       rsp_illegal, rsp_mismatch, busy;
    logic       corrupt = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.DATA_W(8), .OP_W(3), .DEPTH(4), .SETTLE(SETTLE), .TAG_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag),
        .rsp_illegal(rsp_illegal), .rsp_mismatch(rsp_mismatch), .busy(busy)
    );

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h00;
        endcase
        if (corrupt) alu_result = alu_result ^ 8'h01;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [1:0] tag);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("send_ready", cmd_ready, 1);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input logic [7:0] er, input logic [1:0] et, input logic ei,
                           input logic emm, input string nm);
        int n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check({nm, "_valid"}, rsp_valid, 1);
        check({nm, "_result"}, rsp_result, er);
        check({nm, "_tag"}, rsp_tag, et);
        check({nm, "_illegal"}, rsp_illegal, ei);
        check({nm, "_mismatch"}, rsp_mismatch, emm);
        @(negedge clk);
        check({nm, "_hold_valid"}, rsp_valid, 1);
        check({nm, "_hold_result"}, rsp_result, er);
        check({nm, "_hold_tag"}, rsp_tag, et);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int acc;
        int seen;
        logic rdy;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp_result", rsp_result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Case 1: latency and basic ADD
        rsp_ready = 1'b1;
        send(8'd10, 8'd3, 3'd0, 2'd1);
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        check("c1_latency", lat, SETTLE + 2);
        check("c1_result", rsp_result, 8'd13);
        check("c1_tag", rsp_tag, 2'd1);
        check("c1_illegal", rsp_illegal, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("c1_valid_drop", rsp_valid, 0);

        // Case 2: SUB underflow and ADD wrap
        send(8'd3, 8'd10, 3'd1, 2'd2);
        get_rsp(8'hF9, 2'd2, 1'b0, 1'b0, "c2_sub");
        send(8'd200, 8'd100, 3'd0, 2'd3);
        get_rsp(8'd44, 2'd3, 1'b0, 1'b0, "c2_wrap");

        // Case 3: capacity under backpressure, ordering
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_a = 8'(i * 16 + 1); cmd_b = 8'(i); cmd_op = 3'd0; cmd_tag = 2'(i);
            cmd_valid = 1'b1;
            rdy = cmd_ready;
            if (i == 5) check("c3_ready_low_6th", rdy, 0);
            if (rdy) begin
                acc++;
                @(posedge clk);
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        check("c3_accepted", acc, 5);
        for (int i = 0; i < 5; i++) begin
            get_rsp(8'(17 * i + 1), 2'(i), 1'b0, 1'b0, $sformatf("c3_rsp%0d", i));
        end
        repeat (2) @(negedge clk);
        check("c3_busy_idle", busy, 0);

        // Case 4: illegal opcode, then AND
        send(8'hFF, 8'h01, 3'b111, 2'd1);
        get_rsp(8'h00, 2'd1, 1'b1, 1'b0, "c4_ill");
        send(8'hF0, 8'h3C, 3'd2, 2'd2);
        get_rsp(8'h30, 2'd2, 1'b0, 1'b0, "c4_and");

        // Case 5: reset with one in DRIVE and three queued
        for (int i = 0; i < 5; i++) send(8'(i + 1), 8'd1, 3'd0, 2'(i));
        seen = 0;
        while (!rsp_valid && seen < 50) begin @(negedge clk); seen++; end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("c5_pre_busy", busy, 1);
        check("c5_pre_valid", rsp_valid, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("c5_rsp_valid", rsp_valid, 0);
        check("c5_cmd_ready", cmd_ready, 1);
        check("c5_busy", busy, 0);
        check("c5_alu_a", alu_a, 0);
        check("c5_alu_b", alu_b, 0);
        check("c5_alu_op", alu_op, 0);
        check("c5_rsp_result", rsp_result, 0);
        check("c5_rsp_tag", rsp_tag, 0);
        check("c5_rsp_illegal", rsp_illegal, 0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (10) begin @(negedge clk); if (rsp_valid) seen++; end
        check("c5_no_stale", seen, 0);
        check("c5_busy_after", busy, 0);
        rsp_ready = 1'b0;

        // Case 6: faulty ALU then correct ALU on XOR
        corrupt = 1'b1;
        send(8'hAA, 8'h55, 3'd4, 2'd3);
        get_rsp(8'hFE, 2'd3, 1'b0, CHK, "c6_bad");
        corrupt = 1'b0;
        send(8'hAA, 8'h55, 3'd4, 2'd0);
        get_rsp(8'hFF, 2'd0, 1'b0, 1'b0, "c6_good");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
